// File: rtl/bios_ram_arbiter.sv
// Shares the single-port BIOS/program RAM between the ioctl download writer,
// which is buffered in a small FIFO, and the soft CPU, with bounded download bursts.
module bios_ram_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 8,
  parameter int DN_DEPTH = 4,
  parameter int DN_BURST = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [DATA_W-1:0] dn_data,
  output logic              dn_overflow,
  output logic              dn_pending,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam int PTR_W = (DN_DEPTH > 1) ? $clog2(DN_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STK_W = (DN_BURST > 0) ? $clog2(DN_BURST + 1) : 1;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DN_DEPTH);
  localparam logic [STK_W-1:0] BURST_MAX = STK_W'(DN_BURST);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [ENT_W-1:0]  fifo_mem [DN_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic              dn_overflow_q, dn_overflow_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;
  logic [ENT_W-1:0]  head;

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);
  assign head       = fifo_mem[rd_ptr_q];

  // Arbitration: downloads first, but a waiting CPU wins after DN_BURST grants.
  // The cpu_ack cycle is skipped so the CPU can drop its request first.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    cpu_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cpu_ack_q) begin
          if (!fifo_empty && (!cpu_req || streak_q < BURST_MAX)) begin
            pop                     = 1'b1;
            {ram_addr_d, ram_din_d} = head;
            ram_we_d                = 1'b1;
            if (!cpu_req)
              streak_d = '0;
            else if (streak_q != BURST_MAX)
              streak_d = streak_q + STK_W'(1);
          end else if (cpu_req) begin
            streak_d   = '0;
            ram_addr_d = cpu_addr;
            if (cpu_we) begin
              ram_din_d = cpu_din;
              ram_we_d  = 1'b1;
              cpu_ack_d = 1'b1;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end
      RD_WAIT: state_d = RD_DATA;
      RD_DATA: begin
        cpu_dout_d = ram_dout;
        cpu_ack_d  = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A strobe into a full FIFO is accepted when the head leaves in the same cycle.
  always_comb begin
    push          = dn_wr && (!fifo_full || pop);
    dn_overflow_d = dn_overflow_q || (dn_wr && fifo_full && !pop);
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {dn_addr, dn_data};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      streak_q      <= '0;
      dn_overflow_q <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cpu_dout_q    <= '0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      streak_q      <= streak_d;
      dn_overflow_q <= dn_overflow_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_dout_q    <= cpu_dout_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      ram_we_q      <= ram_we_d;
    end
  end

  assign dn_overflow = dn_overflow_q;
  assign dn_pending  = !fifo_empty;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_dout    = cpu_dout_q;
  assign ram_addr    = ram_addr_q;
  assign ram_din     = ram_din_q;
  assign ram_we      = ram_we_q;

endmodule
